// File: rtl/interrupt_controller.sv
// Device-side interrupt controller: prioritises maskable and NMI requests, handshakes with the CPU via savePC.
// Optional macro IRQ_EDGE_EN: when defined, maskable lines pend on a 0->1 edge instead of on level.
module interrupt_controller #(
    parameter int          NUM_IRQ      = 8,
    parameter logic [31:0] MI_END_ADDR  = 32'd0,
    parameter logic [31:0] NMI_END_ADDR = 32'd20,
    parameter logic [3:0]  FETCH_STATE  = 4'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               nmi_req,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               savePC,
    input  logic [31:0]        pcinput,
    input  logic [3:0]         current_state,
    output logic               interrupt,
    output logic               nmint,
    output logic               busy,
    output logic [3:0]         irq_id,
    output logic               eoi
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MI_REQ  = 3'd1,
        NMI_REQ = 3'd2,
        MI_SVC  = 3'd3,
        NMI_SVC = 3'd4
    } state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_set;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [NUM_IRQ-1:0] pend_now;
    logic [NUM_IRQ-1:0] eligible;
    logic               nmi_req_q;
    logic               nmi_pend;
    logic               nmi_edge;
    logic               nmi_now;
    logic               mi_ack;
    logic               nmi_ack;
    logic               mi_done;
    logic               nmi_done;

    function automatic logic [3:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= '0;
        else        irq_q <= irq;
    end

    assign irq_set = irq & ~irq_q;
`else
    assign irq_set = irq;
`endif

    // Incoming sets are folded into arbitration so a new request reaches the CPU one edge later.
    assign nmi_edge = nmi_req & ~nmi_req_q;
    assign nmi_now  = nmi_pend | nmi_edge;
    assign pend_now = pending | irq_set;
    assign eligible = pend_now & mask;

    assign mi_ack   = (state == MI_REQ) && !nmi_now && savePC;
    assign nmi_ack  = (state == NMI_REQ) && savePC;
    assign mi_done  = (state == MI_SVC) && (current_state == FETCH_STATE) &&
                      (pcinput == MI_END_ADDR);
    assign nmi_done = (state == NMI_SVC) && (current_state == FETCH_STATE) &&
                      (pcinput == NMI_END_ADDR);

    always_comb begin
        irq_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (mi_ack && (irq_id == 4'(i))) irq_clr[i] = 1'b1;
        end
    end

    // A set arriving in the same cycle as its clear keeps the source pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask      <= '1;
            pending   <= '0;
            nmi_pend  <= 1'b0;
            nmi_req_q <= 1'b0;
        end else begin
            if (mask_we) mask <= mask_wdata;
            pending   <= (pending & ~irq_clr) | irq_set;
            nmi_pend  <= (nmi_pend & ~nmi_ack) | nmi_edge;
            nmi_req_q <= nmi_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            interrupt <= 1'b0;
            nmint     <= 1'b0;
            busy      <= 1'b0;
            eoi       <= 1'b0;
            irq_id    <= 4'd0;
        end else begin
            eoi <= 1'b0;
            case (state)
                IDLE: begin
                    if (nmi_now) begin
                        state <= NMI_REQ;
                        nmint <= 1'b1;
                    end else if (|eligible) begin
                        state     <= MI_REQ;
                        interrupt <= 1'b1;
                        irq_id    <= lowest_idx(eligible);
                    end
                end
                MI_REQ: begin
                    if (nmi_now) begin
                        state     <= NMI_REQ;
                        interrupt <= 1'b0;
                        nmint     <= 1'b1;
                    end else if (savePC) begin
                        state     <= MI_SVC;
                        interrupt <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                NMI_REQ: begin
                    if (savePC) begin
                        state <= NMI_SVC;
                        nmint <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                MI_SVC: begin
                    if (mi_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        eoi   <= 1'b1;
                    end
                end
                NMI_SVC: begin
                    if (nmi_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        eoi   <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    interrupt <= 1'b0;
                    nmint     <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Device-side end of the CPU interrupt interface: collects device interrupt requests, prioritises them, and drives interrupt/nmint/busy to the multi-cycle control unit.
- Uses savePC as the acknowledge; detects handler completion from the fetch address.
- Sits between peripherals and the control unit; also exposes the serviced source ID for handler dispatch.

Parameters:
- NUM_IRQ, 8, number of maskable request lines (1..16).
- MI_END_ADDR, 32'd0, fetch address of the last instruction of the maskable handler.
- NMI_END_ADDR, 32'd20, fetch address of the last instruction of the NMI handler.
- FETCH_STATE, 4'd0, control-unit state code meaning instruction fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq  in  NUM_IRQ  device requests, active high, level.
- nmi_req  in  1  non-maskable request, rising-edge sensitive.
- mask_we  in  1  mask register write strobe.
- mask_wdata  in  NUM_IRQ  new mask value (1 = enabled).
- savePC  in  1  CPU acknowledge: PC saved, handler entry.
- pcinput  in  32  current PC from the datapath.
- current_state  in  4  control-unit state.
- interrupt  out  1  maskable request to the CPU.
- nmint  out  1  non-maskable request to the CPU.
- busy  out  1  a handler is in service; blocks further maskable entry.
- irq_id  out  4  index of the source being requested or serviced.
- eoi  out  1  one-cycle end-of-interrupt pulse.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mask=all ones; pending=0; nmi_pend=0; nmi edge register=0; interrupt=nmint=busy=eoi=0; irq_id=0.
- pending[i] is set when irq[i]=1. It clears only on acknowledge of source i. A set in the same cycle as the clear wins, so the source stays pending.
- nmi_pend is set on the 0->1 edge of nmi_req (registered edge detect). It clears on acknowledge in NMI_REQ.
- eligible = pending & mask. Priority: lowest index wins. The winning index is latched into irq_id on entry to MI_REQ.
- mask_we updates mask at the next edge. The mask affects new arbitration only; an MI_REQ already raised is not withdrawn.
- FSM, all outputs registered:
  - IDLE: if nmi_pend -> NMI_REQ (nmint=1). Else if eligible!=0 -> MI_REQ (interrupt=1, latch irq_id). NMI takes precedence when both occur in the same cycle.
  - MI_REQ: hold interrupt=1.
    - If nmi_pend -> NMI_REQ: drop interrupt, assert nmint, keep pending.
    - On savePC=1 -> MI_SVC: interrupt=0, busy=1, clear pending[irq_id].
  - NMI_REQ: hold nmint=1. On savePC=1 -> NMI_SVC: nmint=0, busy=1, clear nmi_pend.
  - MI_SVC / NMI_SVC: busy=1. When current_state==FETCH_STATE and pcinput==MI_END_ADDR (resp. NMI_END_ADDR) -> IDLE: eoi=1 for one cycle, busy=0.
  - In MI_SVC, a new nmi_pend keeps the NMI pending until return to IDLE (no nesting).
- Request latency: IDLE with eligible source -> interrupt high on the next clock edge (1 cycle).
- Acknowledge latency: savePC sampled high -> interrupt/nmint low and busy high on that same edge.
- Back-to-back: after eoi, IDLE re-arbitrates on the next cycle; minimum gap between requests is 1 cycle.
- savePC seen in IDLE or *_SVC is ignored (spurious acknowledge).
- Reset mid-service: all state cleared asynchronously; busy drops immediately.

Optional Feature:
- IRQ_EDGE_EN.
- Defined: pending[i] sets only on a 0->1 edge of irq[i] (per-line edge register, reset 0). Holding irq high after acknowledge does not re-trigger.
- Undefined: level-sensitive as above; a line still high after acknowledge re-pends on the next cycle.

Test Plan:
- Reset, then irq=8'b0000_0100 -> interrupt=1 and irq_id=2 one cycle later. Pulse savePC -> interrupt=0, busy=1. Drive current_state=0, pcinput=0 -> eoi pulse, busy=0.
- irq=8'b1010_0000 simultaneously -> irq_id=5 serviced first. After eoi, with irq[7] still high, irq_id=7 next.
- In MI_REQ (irq_id=3), raise nmi_req -> interrupt drops, nmint=1. savePC -> busy=1. pcinput=20 at fetch -> eoi; then interrupt reasserts with irq_id=3.
- mask_wdata=8'b1111_1110, irq=8'b0000_0001 -> no interrupt for 10 cycles. Write mask=all ones -> interrupt=1 the cycle after the write takes effect.
- While in MI_SVC, raise irq[1] -> interrupt stays 0 and busy=1 until eoi. Then interrupt=1 with irq_id=1.
- Assert rst_n=0 mid-NMI_SVC -> busy, nmint, interrupt immediately 0. With IRQ_EDGE_EN, irq[0] held high after service -> no second interrupt.
